key_switch_conditioner: RTL and testbench



---
 rtl/key_switch_conditioner.sv | 120 ++++++++++++
 tb/tb_key_switch_conditioner.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/key_switch_conditioner.sv
// Synchronise, debounce and edge-detect the board keys and slide switches.
// Define KEY_REPEAT_EN to add per-key auto-repeat pulses while a key is held.
module key_switch_conditioner #(
   parameter int KEY_W           = 2,
   parameter int SW_W            = 5,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [KEY_W-1:0] raw_key_n,
   input  logic [SW_W-1:0]  raw_switch,
   output logic [KEY_W-1:0] key,
   output logic [SW_W-1:0]  switch,
   output logic [KEY_W-1:0] key_press_pulse,
   output logic [KEY_W-1:0] key_event,
   input  logic [KEY_W-1:0] key_event_clr
);

   // Keys and switches share one chain; keys idle high (released), switches idle low.
   localparam int N = KEY_W + SW_W;
   localparam logic [N-1:0] RST_VAL = {{SW_W{1'b0}}, {KEY_W{1'b1}}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N-1:0]     raw_all;
   logic [N-1:0]     sync_q [SYNC_STAGES];
   logic [N-1:0]     synced;
   logic [N-1:0]     stable_q;
   logic [CNT_W-1:0] cnt_q [N];
   logic [KEY_W-1:0] key_d;
   logic [KEY_W-1:0] rep_fire;

   assign raw_all = {raw_switch, raw_key_n};
   assign synced  = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RST_VAL;
      end else begin
         sync_q[0] <= raw_all;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_q <= RST_VAL;
         for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (synced[i] == stable_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               stable_q[i] <= synced[i];
               cnt_q[i]    <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Registered outputs add the final cycle of the SYNC_STAGES+DEBOUNCE_CYCLES latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key             <= '0;
         switch          <= '0;
         key_d           <= '0;
         key_press_pulse <= '0;
         key_event       <= '0;
      end else begin
         key             <= ~stable_q[KEY_W-1:0];
         switch          <= stable_q[N-1:KEY_W];
         key_d           <= key;
         key_press_pulse <= (key & ~key_d) | rep_fire;
         key_event       <= (key_event & ~key_event_clr) | key_press_pulse;
      end
   end

`ifdef KEY_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   logic [REP_W-1:0] rep_cnt_q [KEY_W];
   logic [KEY_W-1:0] rep_active_q;

   // Down-counter loaded on the press edge; terminal count fires a pulse and reloads the period.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rep_active_q <= '0;
         for (int i = 0; i < KEY_W; i++) rep_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < KEY_W; i++) begin
            if (!key[i]) begin
               rep_active_q[i] <= 1'b0;
               rep_cnt_q[i]    <= '0;
            end else if (!key_d[i]) begin
               rep_active_q[i] <= 1'b1;
               rep_cnt_q[i]    <= REP_W'(REPEAT_DELAY - 1);
            end else if (rep_active_q[i]) begin
               if (rep_cnt_q[i] == '0) rep_cnt_q[i] <= REP_W'(REPEAT_PERIOD - 1);
               else                    rep_cnt_q[i] <= rep_cnt_q[i] - REP_W'(1);
            end
         end
      end
   end

   always_comb begin
      rep_fire = '0;
      for (int i = 0; i < KEY_W; i++)
         rep_fire[i] = rep_active_q[i] & key[i] & key_d[i] & (rep_cnt_q[i] == '0);
   end
`else
   assign rep_fire = '0;
`endif

endmodule

// File: tb/tb_key_switch_conditioner.sv
// Directed bench for key_switch_conditioner with short debounce and repeat timings.
// Build with KEY_REPEAT_EN defined to cover the auto-repeat behaviour.
module tb_key_switch_conditioner;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] raw_key_n;
   logic [4:0] raw_switch;
   logic [1:0] key;
   logic [4:0] switch;
   logic [1:0] key_press_pulse;
   logic [1:0] key_event;
   logic [1:0] key_event_clr;

   int checks = 0;
   int errors = 0;

`ifdef KEY_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   key_switch_conditioner #(
      .KEY_W(2), .SW_W(5), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .CNT_W(5),
      .REPEAT_DELAY(40), .REPEAT_PERIOD(10)
   ) dut (
      .clk(clk), .reset_n(reset_n), .raw_key_n(raw_key_n), .raw_switch(raw_switch),
      .key(key), .switch(switch), .key_press_pulse(key_press_pulse),
      .key_event(key_event), .key_event_clr(key_event_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      int pulses;
      bit pexp;
      reset_n       = 1'b0;
      raw_key_n     = 2'b11;
      raw_switch    = 5'b00000;
      key_event_clr = 2'b00;
      tick(3);
      check("rst_key", 32'(key), 0);
      check("rst_switch", 32'(switch), 0);
      check("rst_pulse", 32'(key_press_pulse), 0);
      check("rst_event", 32'(key_event), 0);
      reset_n = 1'b1;
      tick(5);
      check("idle_outputs", 32'({key, switch, key_press_pulse, key_event}), 0);

      // 1: clean press on key 0
      raw_key_n[0] = 1'b0;
      tick(18);
      check("t1_key_before", 32'(key[0]), 0);
      tick();
      check("t1_key_rise", 32'(key[0]), 1);
      check("t1_no_pulse_yet", 32'(key_press_pulse), 0);
      tick();
      check("t1_pulse", 32'(key_press_pulse), 2'b01);
      tick();
      check("t1_pulse_gone", 32'(key_press_pulse), 0);
      check("t1_event", 32'(key_event), 2'b01);
      raw_key_n[0] = 1'b1;
      tick(22);
      check("t1_released", 32'(key[0]), 0);
      check("t1_event_sticky", 32'(key_event), 2'b01);

      // 2: short glitches on key 1 (10 and 15 cycles) are rejected
      raw_key_n[1] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t2_glitch10", 32'({key[1], key_press_pulse[1], key_event[1]}), 0);
      end
      raw_key_n[1] = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         check("t2_after10", 32'({key[1], key_press_pulse[1], key_event[1]}), 0);
      end
      raw_key_n[1] = 1'b0;
      tick(15);
      raw_key_n[1] = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         check("t2_after15", 32'({key[1], key_press_pulse[1], key_event[1]}), 0);
      end

      // 3: bouncing switch 3 settles high
      for (int t = 0; t < 12; t++) begin
         raw_switch[3] = ~raw_switch[3];
         for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_bounce", 32'(switch), 0);
         end
      end
      raw_switch[3] = 1'b1;
      for (int i = 0; i < 18; i++) begin
         tick();
         check("t3_settle_wait", 32'(switch), 0);
      end
      tick();
      check("t3_switch_high", 32'(switch), 5'b01000);
      check("t3_keys_quiet", 32'({key, key_press_pulse}), 0);

      // 4: clear coinciding with a new press pulse, then a lone clear
      raw_key_n[0] = 1'b0;
      tick(19);
      check("t4_key", 32'(key[0]), 1);
      tick();
      check("t4_pulse", 32'(key_press_pulse), 2'b01);
      key_event_clr = 2'b01;
      tick();
      key_event_clr = 2'b00;
      check("t4_set_wins", 32'(key_event), 2'b01);
      tick(3);
      key_event_clr = 2'b01;
      tick();
      key_event_clr = 2'b00;
      check("t4_clear", 32'(key_event), 0);
      key_event_clr = 2'b11;
      tick();
      key_event_clr = 2'b00;
      check("t4_clear_idle", 32'(key_event), 0);
      raw_key_n[0] = 1'b1;
      tick(22);
      check("t4_released", 32'(key), 0);

      // 5: reset mid-debounce on key 1
      raw_key_n[1] = 1'b0;
      tick(8);
      reset_n = 1'b0;
      #1;
      check("t5_async_out", 32'({key, switch, key_press_pulse, key_event}), 0);
      tick(2);
      reset_n = 1'b1;
      for (int i = 0; i < 18; i++) begin
         tick();
         check("t5_wait", 32'({key[1], key_press_pulse[1], key_event[1]}), 0);
      end
      tick();
      check("t5_key_rise", 32'(key[1]), 1);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (key_press_pulse[1]) pulses++;
      end
      check("t5_one_pulse", 32'(pulses), 1);
      check("t5_event", 32'(key_event), 2'b10);
      check("t5_switch_back", 32'(switch), 5'b01000);
      raw_key_n[1] = 1'b1;
      tick(22);
      check("t5_released", 32'(key), 0);

      // 6: hold key 0 for 100 cycles past the rise, then release
      raw_key_n[0] = 1'b0;
      tick(19);
      check("t6_key_rise", 32'(key[0]), 1);
      for (int j = 1; j <= 150; j++) begin
         tick();
         pexp = (j == 1) || (REP && j >= 41 && j <= 118 && ((j - 1) % 10) == 0);
         check("t6_key", 32'(key[0]), 32'(j <= 118));
         check("t6_pulse", 32'(key_press_pulse[0]), 32'(pexp));
         if (j == 100) raw_key_n[0] = 1'b1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
